// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the writeback arbiter and the register-file instances.
// Requester indices, the x0 address and the default N/AW widths live here.
package regfile_wb_arbiter_pkg;

  localparam int N_DEF  = 32;
  localparam int AW_DEF = 5;
  localparam int X0     = 0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Outstanding-load scoreboard: one bit per architectural register.
// Set beats clear on the same register; bit 0 is forced low.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [AW-1:0]    set_rd,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_rd,
  output logic [2**AW-1:0] busy
);

  logic [2**AW-1:0] busy_q;
  logic [2**AW-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_rd] = 1'b0;
    // A newly issued load supersedes the one returning to the same register.
    if (set_en) busy_d[set_rd] = 1'b1;
    busy_d[X0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port (ALU vs load return),
// with a one-cycle output register, x0 write suppression and a load scoreboard.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int AW = AW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [AW-1:0]    alu_rd,
  input  logic [N-1:0]     alu_wd,
  output logic             alu_ready,
  input  logic             lsu_valid,
  input  logic [AW-1:0]    lsu_rd,
  input  logic [N-1:0]     lsu_wd,
  output logic             lsu_ready,
  input  logic             hold,
  input  logic             ld_issue,
  input  logic [AW-1:0]    ld_issue_rd,
  output logic             rf_we,
  output logic [AW-1:0]    rf_rd,
  output logic [N-1:0]     rf_wd,
  output logic [2**AW-1:0] sb_busy
);

  // Handshake: a request is accepted when valid && ready in the same cycle;
  // requesters hold valid/rd/wd until then, and ready never looks at data.
  req_e last_q;

  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (!hold) begin
      if (alu_valid && lsu_valid) begin
        if (last_q == REQ_LSU) alu_ready = 1'b1;
        else                   lsu_ready = 1'b1;
      end else begin
        alu_ready = alu_valid;
        lsu_ready = lsu_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= REQ_LSU;
      rf_we  <= 1'b0;
      rf_rd  <= '0;
      rf_wd  <= '0;
    end else if (alu_ready) begin
      last_q <= REQ_ALU;
      rf_we  <= (alu_rd != AW'(X0));
      rf_rd  <= alu_rd;
      rf_wd  <= alu_wd;
    end else if (lsu_ready) begin
      last_q <= REQ_LSU;
      rf_we  <= (lsu_rd != AW'(X0));
      rf_rd  <= lsu_rd;
      rf_wd  <= lsu_wd;
    end else begin
      rf_we  <= 1'b0;
    end
  end

  wb_scoreboard #(.AW(AW)) u_sb (
    .clk    (clk),
    .rst    (rst),
    .set_en (ld_issue && (ld_issue_rd != AW'(X0))),
    .set_rd (ld_issue_rd),
    .clr_en (lsu_ready),
    .clr_rd (lsu_rd),
    .busy   (sb_busy)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Table-driven bench for regfile_wb_arbiter; expected writes queue up one cycle
// ahead and are popped when the output register should show them.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, hold, ld_issue;
  logic [4:0]  alu_rd, lsu_rd, ld_issue_rd;
  logic [31:0] alu_wd, lsu_wd;
  logic        alu_ready, lsu_ready, rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic [31:0] sb_busy;

  int tests = 0;
  int fails = 0;

  // {we, check_data, rd, wd}
  logic [38:0] exp_q[$];
  logic [4:0]  last_rd;
  logic [31:0] last_wd;
  logic        last_ok;

  typedef struct {
    logic        r;
    logic        h;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] awd;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] lwd;
    logic        li;
    logic [4:0]  lird;
    logic        ear;
    logic        elr;
    logic [31:0] esb;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.N(32), .AW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_wd      (alu_wd),
    .alu_ready   (alu_ready),
    .lsu_valid   (lsu_valid),
    .lsu_rd      (lsu_rd),
    .lsu_wd      (lsu_wd),
    .lsu_ready   (lsu_ready),
    .hold        (hold),
    .ld_issue    (ld_issue),
    .ld_issue_rd (ld_issue_rd),
    .rf_we       (rf_we),
    .rf_rd       (rf_rd),
    .rf_wd       (rf_wd),
    .sb_busy     (sb_busy)
  );

  function automatic vec_t mk(logic r, logic h, logic av, logic [4:0] ard, logic [31:0] awd,
                              logic lv, logic [4:0] lrd, logic [31:0] lwd, logic li,
                              logic [4:0] lird, logic ear, logic elr, logic [31:0] esb);
    vec_t v;
    v.r = r; v.h = h; v.av = av; v.ard = ard; v.awd = awd;
    v.lv = lv; v.lrd = lrd; v.lwd = lwd; v.li = li; v.lird = lird;
    v.ear = ear; v.elr = elr; v.esb = esb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    logic [38:0] e;
    @(posedge clk); #1;
    rst = v.r; hold = v.h;
    alu_valid = v.av; alu_rd = v.ard; alu_wd = v.awd;
    lsu_valid = v.lv; lsu_rd = v.lrd; lsu_wd = v.lwd;
    ld_issue = v.li; ld_issue_rd = v.lird;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk({tag, " queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " rf_we"}, {31'd0, rf_we}, {31'd0, e[38]});
      if (e[37]) begin
        chk({tag, " rf_rd"}, {27'd0, rf_rd}, {27'd0, e[36:32]});
        chk({tag, " rf_wd"}, rf_wd, e[31:0]);
      end
    end
    chk({tag, " sb_busy"}, sb_busy, v.esb);
    chk({tag, " alu_ready"}, {31'd0, alu_ready}, {31'd0, v.ear});
    chk({tag, " lsu_ready"}, {31'd0, lsu_ready}, {31'd0, v.elr});
    if (v.r) begin
      e = {1'b0, 1'b1, 5'd0, 32'd0};
      last_rd = 5'd0; last_wd = 32'd0; last_ok = 1'b1;
    end else if (v.ear && v.ard != 5'd0) begin
      e = {1'b1, 1'b1, v.ard, v.awd};
      last_rd = v.ard; last_wd = v.awd; last_ok = 1'b1;
    end else if (v.elr && v.lrd != 5'd0) begin
      e = {1'b1, 1'b1, v.lrd, v.lwd};
      last_rd = v.lrd; last_wd = v.lwd; last_ok = 1'b1;
    end else if (v.ear || v.elr) begin
      e = {1'b0, 1'b0, 5'd0, 32'd0};
      last_ok = 1'b0;
    end else begin
      e = {1'b0, last_ok, last_rd, last_wd};
    end
    exp_q.push_back(e);
  endtask

  initial begin
    logic [4:0]  r1, r2;
    logic [31:0] d1, d2;
    logic        lsu_turn;
    rst = 1'b1; hold = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_wd = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_wd = '0;
    ld_issue = 1'b0; ld_issue_rd = '0;
    last_rd = '0; last_wd = '0; last_ok = 1'b1;

    //                r  h  av ard  awd           lv lrd  lwd      li lird ear elr esb
    tbl.push_back(mk(0, 0, 0, 0,  0,            0, 0,  0,       0, 0,   0, 0, 32'h0));    // 0
    tbl.push_back(mk(0, 0, 1, 5,  32'hDEADBEEF, 0, 0,  0,       0, 0,   1, 0, 32'h0));    // 1
    tbl.push_back(mk(0, 0, 0, 0,  0,            0, 0,  0,       0, 0,   0, 0, 32'h0));    // 2
    tbl.push_back(mk(1, 0, 0, 0,  0,            0, 0,  0,       0, 0,   0, 0, 32'h0));    // 3
    tbl.push_back(mk(0, 0, 1, 1,  32'h11,       1, 2,  32'h22,  0, 0,   1, 0, 32'h0));    // 4
    tbl.push_back(mk(0, 0, 0, 0,  0,            1, 2,  32'h22,  0, 0,   0, 1, 32'h0));    // 5
    tbl.push_back(mk(0, 0, 1, 1,  32'h33,       1, 2,  32'h44,  0, 0,   1, 0, 32'h0));    // 6
    tbl.push_back(mk(0, 0, 1, 1,  32'h33,       1, 2,  32'h44,  0, 0,   0, 1, 32'h0));    // 7
    tbl.push_back(mk(0, 0, 1, 1,  32'h33,       1, 2,  32'h44,  0, 0,   1, 0, 32'h0));    // 8
    tbl.push_back(mk(0, 0, 0, 0,  0,            0, 0,  0,       0, 0,   0, 0, 32'h0));    // 9
    tbl.push_back(mk(0, 0, 0, 0,  0,            0, 0,  0,       1, 7,   0, 0, 32'h0));    // 10
    tbl.push_back(mk(0, 0, 0, 0,  0,            0, 0,  0,       0, 0,   0, 0, 32'h80));   // 11
    tbl.push_back(mk(0, 0, 0, 0,  0,            0, 0,  0,       0, 0,   0, 0, 32'h80));   // 12
    tbl.push_back(mk(0, 0, 0, 0,  0,            1, 7,  32'h77,  0, 0,   0, 1, 32'h80));   // 13
    tbl.push_back(mk(0, 0, 0, 0,  0,            0, 0,  0,       0, 0,   0, 0, 32'h0));    // 14
    tbl.push_back(mk(0, 0, 0, 0,  0,            0, 0,  0,       1, 9,   0, 0, 32'h0));    // 15
    tbl.push_back(mk(0, 0, 0, 0,  0,            1, 9,  32'h99,  1, 9,   0, 1, 32'h200));  // 16
    tbl.push_back(mk(0, 0, 0, 0,  0,            0, 0,  0,       0, 0,   0, 0, 32'h200));  // 17
    tbl.push_back(mk(0, 0, 0, 0,  0,            1, 9,  32'h9A,  1, 0,   0, 1, 32'h200));  // 18
    tbl.push_back(mk(0, 0, 0, 0,  0,            0, 0,  0,       1, 4,   0, 0, 32'h0));    // 19
    tbl.push_back(mk(0, 0, 0, 0,  0,            1, 4,  32'h44,  1, 3,   0, 1, 32'h10));   // 20
    tbl.push_back(mk(0, 0, 0, 0,  0,            0, 0,  0,       0, 0,   0, 0, 32'h8));    // 21
    tbl.push_back(mk(0, 0, 0, 0,  0,            1, 3,  32'h33,  0, 0,   0, 1, 32'h8));    // 22
    tbl.push_back(mk(0, 0, 1, 0,  32'h1234,     0, 0,  0,       0, 0,   1, 0, 32'h0));    // 23
    tbl.push_back(mk(0, 0, 1, 6,  32'h66,       1, 8,  32'h88,  0, 0,   0, 1, 32'h0));    // 24
    tbl.push_back(mk(0, 1, 1, 6,  32'h66,       1, 8,  32'h88,  0, 0,   0, 0, 32'h0));    // 25
    tbl.push_back(mk(0, 1, 1, 6,  32'h66,       1, 8,  32'h88,  0, 0,   0, 0, 32'h0));    // 26
    tbl.push_back(mk(0, 1, 1, 6,  32'h66,       1, 8,  32'h88,  1, 10,  0, 0, 32'h0));    // 27
    tbl.push_back(mk(0, 0, 1, 6,  32'h66,       1, 8,  32'h88,  0, 0,   1, 0, 32'h400));  // 28
    tbl.push_back(mk(1, 0, 0, 0,  0,            0, 0,  0,       0, 0,   0, 0, 32'h400));  // 29
    tbl.push_back(mk(1, 0, 1, 11, 32'hB0B,      0, 0,  0,       0, 0,   1, 0, 32'h0));    // 30
    tbl.push_back(mk(0, 0, 0, 0,  0,            0, 0,  0,       0, 0,   0, 0, 32'h0));    // 31
    tbl.push_back(mk(0, 0, 1, 12, 32'hC,        1, 13, 32'hD,   0, 0,   1, 0, 32'h0));    // 32
    tbl.push_back(mk(0, 0, 0, 0,  0,            0, 0,  0,       0, 0,   0, 0, 32'h0));    // 33

    repeat (2) @(posedge clk);
    exp_q.push_back({1'b0, 1'b1, 5'd0, 32'd0});

    foreach (tbl[i]) step(tbl[i], $sformatf("row%0d", i));

    // Persistent contention after row 32 (ALU won last): grants must alternate from LSU.
    lsu_turn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      r1 = 5'($urandom_range(1, 31));
      r2 = 5'($urandom_range(1, 31));
      d1 = $urandom;
      d2 = $urandom;
      step(mk(0, 0, 1, r1, d1, 1, r2, d2, 0, 0, !lsu_turn, lsu_turn, 32'h0),
           $sformatf("alt%0d", i));
      lsu_turn = !lsu_turn;
    end
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0), "drain0");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0), "drain1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two requesters: the ALU/branch writeback (req 0) and the load-unit return (req 1).
- Arbitrates round-robin, registers the winning write onto the port one cycle later, and suppresses writes to x0.
- Keeps a per-register scoreboard of outstanding loads so the issue stage can stall on RAW hazards.
- Sits between execute/LSU and the register file in the RV32I core.

Parameters:
- N, 32, data width of a write.
- AW, 5, register address width; the scoreboard has 2**AW bits.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU write request.
- alu_rd  in  AW  ALU destination register.
- alu_wd  in  N  ALU write data.
- alu_ready  out  1  ALU request granted this cycle.
- lsu_valid  in  1  load-return write request.
- lsu_rd  in  AW  load destination register.
- lsu_wd  in  N  load data.
- lsu_ready  out  1  load request granted this cycle.
- hold  in  1  blocks all grants (debug/flush).
- ld_issue  in  1  a load is being issued this cycle.
- ld_issue_rd  in  AW  destination of the issued load.
- rf_we  out  1  register-file write enable.
- rf_rd  out  AW  register-file write address.
- rf_wd  out  N  register-file write data.
- sb_busy  out  2**AW  bit i = 1 when a load to xi is outstanding.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values: rf_we=0, rf_rd=0, rf_wd=0, sb_busy=0. The last-grant pointer is set to LSU, so the ALU wins the first tie after reset.
- Handshake: a request is accepted in a cycle where valid=1 and ready=1. Requesters hold valid, rd and wd stable until accepted. ready depends combinationally on valid, hold and the pointer only, never on data.
- Grant rules:
  - hold=1: both ready=0, pointer unchanged.
  - Only one valid: that requester is granted.
  - Both valid: the requester not named by the pointer is granted.
  - The pointer updates to the granted requester on every grant.
  - At most one grant per cycle.
- Write latency: the cycle after a grant, rf_we=1 with rf_rd/rf_wd equal to the accepted rd/wd (one register stage, latency 1). In cycles with no grant, rf_we=0 on the next edge; rf_rd and rf_wd hold their last values.
- x0 handling: a grant with rd=0 is a normal accept (ready=1, pointer updates), but the following cycle has rf_we=0.
- Scoreboard:
  - ld_issue=1 with ld_issue_rd≠0 sets sb_busy[ld_issue_rd] on the next edge.
  - An accepted LSU request clears sb_busy[lsu_rd] on the next edge.
  - Same-cycle set and clear of the same rd: set wins, because the new load supersedes the old one.
  - sb_busy[0] is always 0.
  - Set and clear of different registers in the same cycle both take effect.
- hold: does not affect the scoreboard or the output register's clearing of rf_we.
- Reset mid-operation: an accepted-but-unwritten request is dropped (rf_we=0 next cycle) and the scoreboard clears. Requesters must reissue.
- No combinational path from alu_wd/lsu_wd to any output.

Decomposition:
- Shared package/header:
  - requester index constants REQ_ALU=0 and REQ_LSU=1;
  - the X0 address constant;
  - defaults for N and AW, shared with the register-file Register instances.
- One natural sub-module, wb_scoreboard: the 2**AW-bit set/clear array with set priority and the x0 mask.
- The round-robin pick and the output register stay in the top module.

Test Plan:
- Reset then alu_valid=1 with rd=5, wd=0xDEADBEEF -> alu_ready=1 in cycle 0; in cycle 1, rf_we=1, rf_rd=5, rf_wd=0xDEADBEEF. sb_busy stays 0.
- Both valid every cycle (ALU rd=1, LSU rd=2), each side dropping valid after its accept, with hold=0 -> grant order ALU then LSU. Writes appear on cycles 1 and 2. With persistent requests, grants alternate strictly.
- ld_issue with rd=7 in cycle 0 -> sb_busy[7]=1 from cycle 1. LSU return for rd=7 granted in cycle 3 -> sb_busy[7]=0 from cycle 4, rf_we=1 with rf_rd=7 in cycle 4.
- Same cycle: ld_issue rd=9 and LSU accept for rd=9 -> sb_busy[9] stays 1. With ld_issue_rd=0 -> sb_busy stays all-zero.
- ALU request with rd=0, wd=0x1234 -> alu_ready=1, rf_we=0 in the next cycle. Pointer moves, so a subsequent tie grants LSU.
- hold=1 for 3 cycles with both valid -> no ready, rf_we=0. Release hold -> the granted requester follows the pointer. Assert rst the cycle after a grant -> rf_we=0 next cycle and sb_busy=0.
